// File: rtl/rv_pkg.sv
// Shared uop and issue-queue entry types, plus the modular age compare.
package rv_pkg;
   localparam int TAG_W   = 6;
   localparam int SQN_W   = 6;
   localparam int NMDST_W = 5;
   localparam int OPC_W   = 6;
   localparam int PORT_W  = 3;   // stored port-mask width; NUM_DEQ must not exceed it

   typedef enum logic [1:0] {FU_INT, FU_MUL, FU_DIV, FU_LSU} FuncUnit;

   typedef struct packed {
      logic [TAG_W-1:0]   tagA;
      logic [TAG_W-1:0]   tagB;
      logic               availA;
      logic               availB;
      logic [TAG_W-1:0]   tagDst;
      logic [NMDST_W-1:0] nmDst;
      logic [SQN_W-1:0]   sqN;
      FuncUnit            fu;
      logic [OPC_W-1:0]   opcode;
   } R_UOp;

   typedef struct packed {
      R_UOp              uop;
      logic [PORT_W-1:0] portMask;
      logic              valid;
   } iq_entry_t;

   // a is older than b when (a - b) is negative modulo 2^SQN_W
   function automatic logic sqn_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
      logic [SQN_W-1:0] diff;
      diff = a - b;
      return diff[SQN_W-1];
   endfunction
endpackage

// File: rtl/iq_select.sv
// Combinational oldest-ready picker for a single issue port.
module iq_select
   import rv_pkg::*;
#(
   parameter int QUEUE_SIZE = 16,
   parameter int IDX_W      = 4
) (
   input  logic [QUEUE_SIZE-1:0] ready,
   input  logic [QUEUE_SIZE-1:0] port_ok,
   input  logic [QUEUE_SIZE-1:0] exclude,
   input  logic [SQN_W-1:0]      sqn [QUEUE_SIZE],
   output logic                  pick_valid,
   output logic [IDX_W-1:0]      pick_idx
);
   logic [SQN_W-1:0] best_sqn;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      best_sqn   = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         if (ready[i] && port_ok[i] && !exclude[i]) begin
            if (!pick_valid || sqn_older(sqn[i], best_sqn)) begin
               pick_valid = 1'b1;
               pick_idx   = IDX_W'(i);
               best_sqn   = sqn[i];
            end
         end
      end
   end
endmodule

// File: rtl/issue_queue_multiport.sv
// Out-of-order issue queue: wakeup from buses and INT forwarding, oldest-first issue per port, flush.
module issue_queue_multiport
   import rv_pkg::*;
#(
   parameter int NUM_ENQ          = 2,
   parameter int NUM_DEQ          = 3,
   parameter int QUEUE_SIZE       = 16,
   parameter int RESULT_BUS_COUNT = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              frontEn,
   input  logic [NUM_ENQ-1:0]                IN_uopValid,
   input  R_UOp                              IN_uop [NUM_ENQ],
   input  logic [NUM_DEQ-1:0]                IN_portMask [NUM_ENQ],
   input  logic [NUM_DEQ-1:0]                IN_stall,
   input  logic [RESULT_BUS_COUNT-1:0]       IN_resultValid,
   input  logic [TAG_W-1:0]                  IN_resultTag [RESULT_BUS_COUNT],
   input  logic                              IN_invalidate,
   input  logic [SQN_W-1:0]                  IN_invalidateSqN,
   output logic [NUM_DEQ-1:0]                OUT_valid,
   output R_UOp                              OUT_uop [NUM_DEQ],
   output logic [$clog2(QUEUE_SIZE+1)-1:0]   OUT_free
);
   localparam int IDX_W  = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
   localparam int FREE_W = $clog2(QUEUE_SIZE+1);

   iq_entry_t q [QUEUE_SIZE];

   logic [QUEUE_SIZE-1:0] wake_a, wake_b, ready, valid_nxt;
   logic [QUEUE_SIZE-1:0] port_col [NUM_DEQ];
   logic [QUEUE_SIZE-1:0] excl [NUM_DEQ];
   logic [SQN_W-1:0]      sqn_arr [QUEUE_SIZE];
   logic                  pick_vld [NUM_DEQ];
   logic                  issue_go [NUM_DEQ];
   logic [IDX_W-1:0]      pick_idx [NUM_DEQ];
   logic                  enq_ok [NUM_ENQ];
   logic [IDX_W-1:0]      enq_idx [NUM_ENQ];
   R_UOp                  enq_uop [NUM_ENQ];
   logic [NUM_ENQ-1:0]    enq_drop;
   logic [FREE_W-1:0]     used_nxt;

   // Result-bus hit or forward from a single-cycle INT op issued last cycle on any port
   function automatic logic tag_hit(input logic [TAG_W-1:0] tag);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < RESULT_BUS_COUNT; k++)
         if (IN_resultValid[k] && IN_resultTag[k] == tag) hit = 1'b1;
      for (int p = 0; p < NUM_DEQ; p++)
         if (OUT_valid[p] && OUT_uop[p].fu == FU_INT && OUT_uop[p].nmDst != '0 &&
             OUT_uop[p].tagDst == tag) hit = 1'b1;
      return hit;
   endfunction

   always_comb begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         wake_a[i]  = q[i].uop.availA | tag_hit(q[i].uop.tagA);
         wake_b[i]  = q[i].uop.availB | tag_hit(q[i].uop.tagB);
         ready[i]   = q[i].valid & wake_a[i] & wake_b[i];
         sqn_arr[i] = q[i].uop.sqN;
      end
      for (int p = 0; p < NUM_DEQ; p++)
         for (int i = 0; i < QUEUE_SIZE; i++)
            port_col[p][i] = q[i].portMask[p];
   end

   // Highest port picks first; each lower port excludes what the ports above it issued
   assign excl[NUM_DEQ-1] = '0;
   for (genvar p = NUM_DEQ - 1; p >= 0; p--) begin : g_port
      iq_select #(.QUEUE_SIZE(QUEUE_SIZE), .IDX_W(IDX_W)) u_sel (
         .ready      (ready),
         .port_ok    (port_col[p]),
         .exclude    (excl[p]),
         .sqn        (sqn_arr),
         .pick_valid (pick_vld[p]),
         .pick_idx   (pick_idx[p])
      );
      assign issue_go[p] = pick_vld[p] & ~IN_stall[p] & ~IN_invalidate;
      if (p > 0) begin : g_chain
         assign excl[p-1] = excl[p] | (issue_go[p] ? (QUEUE_SIZE'(1) << pick_idx[p]) : '0);
      end
   end

   // Allocation only sees entries free before this edge, so issued slots are not reused yet
   always_comb begin
      logic [QUEUE_SIZE-1:0] taken;
      taken = '0;
      for (int s = 0; s < NUM_ENQ; s++) begin
         enq_ok[s]         = 1'b0;
         enq_idx[s]        = '0;
         enq_drop[s]       = 1'b0;
         enq_uop[s]        = IN_uop[s];
         enq_uop[s].availA = IN_uop[s].availA | tag_hit(IN_uop[s].tagA);
         enq_uop[s].availB = IN_uop[s].availB | tag_hit(IN_uop[s].tagB);
         if (frontEn && IN_uopValid[s] && !IN_invalidate) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
               if (!q[i].valid && !taken[i] && !enq_ok[s]) begin
                  enq_ok[s]  = 1'b1;
                  enq_idx[s] = IDX_W'(i);
                  taken[i]   = 1'b1;
               end
            end
            enq_drop[s] = !enq_ok[s];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < QUEUE_SIZE; i++)
         valid_nxt[i] = q[i].valid & ~(IN_invalidate & sqn_older(IN_invalidateSqN, q[i].uop.sqN));
      for (int p = 0; p < NUM_DEQ; p++)
         if (issue_go[p]) valid_nxt[pick_idx[p]] = 1'b0;
      for (int s = 0; s < NUM_ENQ; s++)
         if (enq_ok[s]) valid_nxt[enq_idx[s]] = 1'b1;
      used_nxt = '0;
      for (int i = 0; i < QUEUE_SIZE; i++)
         used_nxt = used_nxt + FREE_W'(valid_nxt[i]);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         q[i].uop.availA <= wake_a[i];
         q[i].uop.availB <= wake_b[i];
      end
      for (int s = 0; s < NUM_ENQ; s++) begin
         if (enq_ok[s]) begin
            q[enq_idx[s]].uop      <= enq_uop[s];
            q[enq_idx[s]].portMask <= PORT_W'(IN_portMask[s]);
         end
      end
      for (int p = 0; p < NUM_DEQ; p++)
         if (issue_go[p]) OUT_uop[p] <= q[pick_idx[p]].uop;

      if (rst) begin
         for (int i = 0; i < QUEUE_SIZE; i++) q[i].valid <= 1'b0;
         OUT_valid <= '0;
         OUT_free  <= FREE_W'(QUEUE_SIZE);
      end else begin
         for (int i = 0; i < QUEUE_SIZE; i++) q[i].valid <= valid_nxt[i];
         OUT_free <= FREE_W'(QUEUE_SIZE) - used_nxt;
         for (int p = 0; p < NUM_DEQ; p++) begin
            if (IN_invalidate) begin
               if (OUT_valid[p] && sqn_older(IN_invalidateSqN, OUT_uop[p].sqN)) OUT_valid[p] <= 1'b0;
            end else if (!IN_stall[p]) begin
               OUT_valid[p] <= issue_go[p];
            end
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst) enq_drop == '0);
endmodule

// File: tb/tb_issue_queue_multiport.sv
// Directed bench for issue_queue_multiport: ordering, wakeup/forwarding, wrap, flush, full, reset.
module tb_issue_queue_multiport;
   import rv_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             frontEn;
   logic [1:0]       uop_valid;
   R_UOp             uop_in [2];
   logic [2:0]       pmask [2];
   logic [2:0]       stall;
   logic [2:0]       res_valid;
   logic [TAG_W-1:0] res_tag [3];
   logic             inval;
   logic [SQN_W-1:0] inval_sqn;
   logic [2:0]       out_valid;
   R_UOp             out_uop [3];
   logic [4:0]       out_free;

   int n_cmp = 0;
   int n_bad = 0;

   issue_queue_multiport dut (
      .clk              (clk),
      .rst              (rst),
      .frontEn          (frontEn),
      .IN_uopValid      (uop_valid),
      .IN_uop           (uop_in),
      .IN_portMask      (pmask),
      .IN_stall         (stall),
      .IN_resultValid   (res_valid),
      .IN_resultTag     (res_tag),
      .IN_invalidate    (inval),
      .IN_invalidateSqN (inval_sqn),
      .OUT_valid        (out_valid),
      .OUT_uop          (out_uop),
      .OUT_free         (out_free)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [2:0] ov, input logic [4:0] free);
      chk({tag, "_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, "_free"}, 32'(out_free), 32'(free));
   endtask

   function automatic R_UOp mk(input logic [5:0] sqn, input logic [5:0] tag_a, input logic avail_a,
                               input logic [5:0] tag_dst, input logic [4:0] nm_dst);
      R_UOp u;
      u        = '0;
      u.sqN    = sqn;
      u.tagA   = tag_a;
      u.availA = avail_a;
      u.availB = 1'b1;
      u.tagDst = tag_dst;
      u.nmDst  = nm_dst;
      u.fu     = FU_INT;
      u.opcode = sqn;
      return u;
   endfunction

   task automatic enq(input int slot, input R_UOp u, input logic [2:0] m);
      uop_in[slot]    = u;
      pmask[slot]     = m;
      uop_valid[slot] = 1'b1;
      frontEn         = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      frontEn   = 1'b0;
      uop_valid = '0;
      res_valid = '0;
      inval     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; frontEn = 1'b0; uop_valid = '0; stall = '0; res_valid = '0; inval = 1'b0;
      inval_sqn = '0;
      for (int i = 0; i < 2; i++) begin uop_in[i] = '0; pmask[i] = 3'b001; end
      for (int i = 0; i < 3; i++) res_tag[i] = '0;
      step(); step();
      chk_state("reset", 3'b000, 5'd16);
      rst = 1'b0;

      // 1: oldest-first on port 0
      enq(0, mk(6'd5, 6'd0, 1'b1, 6'd1, 5'd0), 3'b001);
      enq(1, mk(6'd3, 6'd0, 1'b1, 6'd2, 5'd0), 3'b001);
      step(); chk_state("t1_e0", 3'b000, 5'd14);
      enq(0, mk(6'd4, 6'd0, 1'b1, 6'd3, 5'd0), 3'b001);
      step(); chk_state("t1_e1", 3'b001, 5'd14); chk("t1_e1_sqn", 32'(out_uop[0].sqN), 32'd3);
      step(); chk_state("t1_e2", 3'b001, 5'd15); chk("t1_e2_sqn", 32'(out_uop[0].sqN), 32'd4);
      step(); chk_state("t1_e3", 3'b001, 5'd16); chk("t1_e3_sqn", 32'(out_uop[0].sqN), 32'd5);
      step(); chk_state("t1_idle", 3'b000, 5'd16);

      // 2: INT forwarding across ports, then bus wakeup when nmDst is 0
      enq(0, mk(6'd10, 6'd0, 1'b1, 6'd9, 5'd1), 3'b001);
      enq(1, mk(6'd11, 6'd9, 1'b0, 6'd20, 5'd0), 3'b010);
      step(); chk_state("t2_e0", 3'b000, 5'd14);
      step(); chk_state("t2_e1", 3'b001, 5'd15); chk("t2_e1_sqn", 32'(out_uop[0].sqN), 32'd10);
      step(); chk_state("t2_e2", 3'b010, 5'd16); chk("t2_e2_sqn", 32'(out_uop[1].sqN), 32'd11);
      enq(0, mk(6'd12, 6'd0, 1'b1, 6'd9, 5'd0), 3'b001);
      enq(1, mk(6'd13, 6'd9, 1'b0, 6'd21, 5'd0), 3'b010);
      step(); chk_state("t2b_e0", 3'b000, 5'd14);
      step(); chk_state("t2b_e1", 3'b001, 5'd15);
      step(); chk_state("t2b_nofwd", 3'b000, 5'd15);
      res_valid[0] = 1'b1; res_tag[0] = 6'd9;
      step(); chk_state("t2b_bus", 3'b010, 5'd16); chk("t2b_bus_sqn", 32'(out_uop[1].sqN), 32'd13);

      // 3: sequence-number wrap
      stall = 3'b001;
      enq(0, mk(6'd0, 6'd0, 1'b1, 6'd4, 5'd0), 3'b001);
      enq(1, mk(6'd1, 6'd0, 1'b1, 6'd5, 5'd0), 3'b001);
      step(); chk_state("t3_e0", 3'b000, 5'd14);
      enq(0, mk(6'd62, 6'd0, 1'b1, 6'd6, 5'd0), 3'b001);
      enq(1, mk(6'd63, 6'd0, 1'b1, 6'd7, 5'd0), 3'b001);
      step(); chk_state("t3_stall", 3'b000, 5'd12);
      stall = 3'b000;
      step(); chk_state("t3_i0", 3'b001, 5'd13); chk("t3_i0_sqn", 32'(out_uop[0].sqN), 32'd62);
      step(); chk_state("t3_i1", 3'b001, 5'd14); chk("t3_i1_sqn", 32'(out_uop[0].sqN), 32'd63);
      step(); chk_state("t3_i2", 3'b001, 5'd15); chk("t3_i2_sqn", 32'(out_uop[0].sqN), 32'd0);
      step(); chk_state("t3_i3", 3'b001, 5'd16); chk("t3_i3_sqn", 32'(out_uop[0].sqN), 32'd1);
      step(); chk_state("t3_idle", 3'b000, 5'd16);

      // 4: flush younger than sqN 10, including an issued output
      stall = 3'b001;
      enq(0, mk(6'd13, 6'd0, 1'b1, 6'd8, 5'd0), 3'b100);
      enq(1, mk(6'd8, 6'd0, 1'b1, 6'd10, 5'd0), 3'b001);
      step(); chk_state("t4_e0", 3'b000, 5'd14);
      enq(0, mk(6'd11, 6'd0, 1'b1, 6'd11, 5'd0), 3'b001);
      enq(1, mk(6'd12, 6'd0, 1'b1, 6'd12, 5'd0), 3'b001);
      step(); chk_state("t4_e1", 3'b100, 5'd13); chk("t4_e1_sqn", 32'(out_uop[2].sqN), 32'd13);
      stall = 3'b000;
      inval = 1'b1; inval_sqn = 6'd10;
      enq(0, mk(6'd14, 6'd0, 1'b1, 6'd13, 5'd0), 3'b001);
      step(); chk_state("t4_flush", 3'b000, 5'd15);
      step(); chk_state("t4_after", 3'b001, 5'd16); chk("t4_after_sqn", 32'(out_uop[0].sqN), 32'd8);
      step(); chk_state("t4_idle", 3'b000, 5'd16);

      // 5: fill under stall, bus wakes the 4 oldest, then 3 issue in one edge
      stall = 3'b111;
      for (int k = 0; k < 8; k++) begin
         enq(0, mk(6'(20 + 2*k), 6'd33, (20 + 2*k) >= 24, 6'd14, 5'd0), 3'b111);
         enq(1, mk(6'(21 + 2*k), 6'd33, (21 + 2*k) >= 24, 6'd15, 5'd0), 3'b111);
         step();
      end
      chk_state("t5_full", 3'b000, 5'd0);
      res_valid[0] = 1'b1; res_tag[0] = 6'd33;
      step(); chk_state("t5_wake", 3'b000, 5'd0);
      stall = 3'b000;
      step(); chk_state("t5_issue", 3'b111, 5'd3);
      chk("t5_p2_sqn", 32'(out_uop[2].sqN), 32'd20);
      chk("t5_p1_sqn", 32'(out_uop[1].sqN), 32'd21);
      chk("t5_p0_sqn", 32'(out_uop[0].sqN), 32'd22);
      for (int k = 0; k < 5; k++) step();
      chk("t5_drain_free", 32'(out_free), 32'd16);
      step(); chk_state("t5_idle", 3'b000, 5'd16);

      // 6: same-cycle bus capture on enqueue
      enq(0, mk(6'd40, 6'd50, 1'b0, 6'd16, 5'd0), 3'b001);
      res_valid[1] = 1'b1; res_tag[1] = 6'd50;
      step(); chk_state("t6_e0", 3'b000, 5'd15);
      step(); chk_state("t6_e1", 3'b001, 5'd16); chk("t6_e1_sqn", 32'(out_uop[0].sqN), 32'd40);

      // 7: reset in the middle of traffic
      enq(0, mk(6'd41, 6'd0, 1'b1, 6'd17, 5'd0), 3'b001);
      enq(1, mk(6'd42, 6'd0, 1'b1, 6'd18, 5'd0), 3'b001);
      step(); chk_state("t7_e0", 3'b000, 5'd14);
      rst = 1'b1;
      enq(0, mk(6'd43, 6'd0, 1'b1, 6'd19, 5'd0), 3'b001);
      step(); chk_state("t7_rst", 3'b000, 5'd16);
      rst = 1'b0;
      step(); chk_state("t7_post", 3'b000, 5'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
